// File: rtl/lfsr_shuffle_rotator.sv
// lfsr_shuffle_rotator
// Number scrambler for the game datapath. A start pulse captures I_NUM and
// applies a fixed stride bit-permutation. The permuted word is then rotated
// left, one bit per cycle, by an amount drawn from a free-running 16-bit LFSR.
// The result is reported with a single-cycle valid pulse.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      asynchronous reset, active high
//   I_SEED_LD  in   1      (SEED_LOAD_EN only) load I_SEED into the LFSR
//   I_SEED     in   16     (SEED_LOAD_EN only) LFSR seed; 0 is replaced by 1
//   I_START    in   1      start request, sampled only in IDLE
//   I_NUM      in   WIDTH  number to scramble, captured with I_START
//   O_NUM      out  WIDTH  scrambled result, held until the next completion
//   O_VALID    out  1      one-cycle pulse when O_NUM updates
//   O_BUSY     out  1      high while an operation is in flight
//   O_SHIFT    out  SW     rotation amount of the current/last operation
//
// Configuration macro: SEED_LOAD_EN adds the run-time seed load ports.
//
// state  | meaning
// IDLE   | waiting for I_START
// DRAW   | rejection-sampling a rotation amount from the LFSR
// ROTATE | rotating the work word left one bit per cycle
// DONE   | publishing the result and pulsing O_VALID

module lfsr_shuffle_rotator #(
    parameter int          WIDTH   = 10,
    parameter int          STRIDE  = 3,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          MAX_TRY = 8,
    localparam int         SW      = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef SEED_LOAD_EN
    input  logic             I_SEED_LD,
    input  logic [15:0]      I_SEED,
`endif
    input  logic             I_START,
    input  logic [WIDTH-1:0] I_NUM,
    output logic [WIDTH-1:0] O_NUM,
    output logic             O_VALID,
    output logic             O_BUSY,
    output logic [SW-1:0]    O_SHIFT
);

    localparam int          TW       = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        ROTATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d, lfsr_step;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] mid;
    logic [SW-1:0]    count_q, count_d;
    logic [SW-1:0]    shift_q, shift_d;
    logic [TW-1:0]    try_q, try_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    cand;

    // Stride permutation; STRIDE coprime to WIDTH makes this a bijection.
    always_comb begin
        mid = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mid[i] = I_NUM[(i * STRIDE) % WIDTH];
        end
    end

    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef SEED_LOAD_EN
    always_comb begin
        lfsr_d = lfsr_step;
        if (I_SEED_LD) begin
            lfsr_d = (I_SEED == 16'h0000) ? 16'h0001 : I_SEED;
        end
    end
`else
    assign lfsr_d = lfsr_step;
`endif

    // DRAW always samples the current register value, so a same-cycle seed
    // load only affects later draws.
    assign cand = lfsr_q[SW-1:0];

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        shift_d = shift_q;
        try_d   = try_q;
        num_d   = num_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_START) begin
                    work_d  = mid;
                    try_d   = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (int'(cand) < WIDTH) begin
                    shift_d = cand;
                    count_d = cand;
                    state_d = ROTATE;
                end else if (int'(try_q) < MAX_TRY - 1) begin
                    try_d = try_q + 1'b1;
                end else begin
                    // Out of attempts: fold the candidate back into range.
                    shift_d = SW'(int'(cand) - WIDTH);
                    count_d = SW'(int'(cand) - WIDTH);
                    state_d = ROTATE;
                end
            end
            ROTATE: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    work_d  = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                    count_d = count_q - 1'b1;
                end
            end
            DONE: begin
                num_d   = work_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            work_q  <= '0;
            count_q <= '0;
            shift_q <= '0;
            try_q   <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            work_q  <= work_d;
            count_q <= count_d;
            shift_q <= shift_d;
            try_q   <= try_d;
            num_q   <= num_d;
            valid_q <= valid_d;
        end
    end

    assign O_NUM   = num_q;
    assign O_VALID = valid_q;
    assign O_SHIFT = shift_q;
    // Registered result/valid land on the edge that returns the FSM to IDLE,
    // so busy is already low while O_VALID is high.
    assign O_BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_shuffle_rotator.sv
// Directed testbench for lfsr_shuffle_rotator (default parameters).
module tb_lfsr_shuffle_rotator;

    logic       CLK = 1'b0;
    logic       RST;
    logic       I_START;
    logic [9:0] I_NUM;
    logic [9:0] O_NUM;
    logic       O_VALID;
    logic       O_BUSY;
    logic [3:0] O_SHIFT;
`ifdef SEED_LOAD_EN
    logic        I_SEED_LD;
    logic [15:0] I_SEED;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;

    lfsr_shuffle_rotator dut (
        .CLK       (CLK),
        .RST       (RST),
`ifdef SEED_LOAD_EN
        .I_SEED_LD (I_SEED_LD),
        .I_SEED    (I_SEED),
`endif
        .I_START   (I_START),
        .I_NUM     (I_NUM),
        .O_NUM     (O_NUM),
        .O_VALID   (O_VALID),
        .O_BUSY    (O_BUSY),
        .O_SHIFT   (O_SHIFT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [9:0] perm(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[(i * 3) % 10];
        return r;
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] v, input int s);
        logic [9:0] r;
        r = v;
        for (int k = 0; k < s; k++) r = {r[8:0], r[9]};
        return r;
    endfunction

    // Rejection sampling as seen from the first DRAW cycle's LFSR value.
    task automatic draw(input logic [15:0] l0, output int sh, output int tries);
        logic [15:0] l;
        int t, c;
        l = l0;
        t = 0;
        c = int'(l[3:0]);
        while (c >= 10 && t < 7) begin
            t++;
            l = step(l);
            c = int'(l[3:0]);
        end
        tries = t + 1;
        sh = (c >= 10) ? c - 10 : c;
    endtask

    // Reference LFSR, reset and clocked alongside the DUT.
    always @(posedge CLK or posedge RST) begin
        if (RST) m_lfsr <= 16'hACE1;
`ifdef SEED_LOAD_EN
        else if (I_SEED_LD) m_lfsr <= (I_SEED == 16'h0) ? 16'h0001 : I_SEED;
`endif
        else m_lfsr <= step(m_lfsr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [9:0] num, input bit poke);
        logic [15:0] l0;
        logic [9:0]  exp_num;
        int sh, tries, n;
        bit got;
        @(negedge CLK);
        I_NUM   = num;
        I_START = 1'b1;
        @(negedge CLK);
        I_START = 1'b0;
        l0 = m_lfsr;
        draw(l0, sh, tries);
        exp_num = rotl(perm(num), sh);
        check("busy_after_start", 32'(O_BUSY), 32'd1);
        n = 0;
        got = 1'b0;
        while (n < 60 && !got) begin
            @(negedge CLK);
            n++;
            if (poke && n == 1) I_START = 1'b1;
            if (poke && n == 2) I_START = 1'b0;
            if (O_VALID) got = 1'b1;
        end
        I_START = 1'b0;
        check("valid_seen", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(2 + tries + sh));
        check("o_num", 32'(O_NUM), 32'(exp_num));
        check("o_shift", 32'(O_SHIFT), 32'(sh));
        check("busy_at_valid", 32'(O_BUSY), 32'd0);
        @(negedge CLK);
        check("valid_single", 32'(O_VALID), 32'd0);
        check("no_restart", 32'(O_BUSY), 32'd0);
    endtask

    initial begin : main
        int pulses, tries, sh, n;
        bit prev_valid;
        logic [3:0] s1;

        RST     = 1'b1;
        I_START = 1'b0;
        I_NUM   = '0;
`ifdef SEED_LOAD_EN
        I_SEED_LD = 1'b0;
        I_SEED    = '0;
`endif
        // Reset state and quiet idle.
        @(negedge CLK);
        check("rst_num", 32'(O_NUM), 32'd0);
        check("rst_valid", 32'(O_VALID), 32'd0);
        check("rst_busy", 32'(O_BUSY), 32'd0);
        check("rst_shift", 32'(O_SHIFT), 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("idle_no_valid", 32'(O_VALID), 32'd0);
        end

        // Single-bit input, all-ones, all-zeros, a few patterns.
        run_op(10'h001, 1'b0);
        run_op(10'h3FF, 1'b0);
        check("ones_identity", 32'(O_NUM), 32'h3FF);
        run_op(10'h000, 1'b0);
        check("zero_identity", 32'(O_NUM), 32'h000);
        run_op(10'h2A5, 1'b0);

        // Mid-cycle reset clears outputs immediately.
        #2 RST = 1'b1;
        #1;
        check("async_rst_num", 32'(O_NUM), 32'd0);
        check("async_rst_valid", 32'(O_VALID), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Start while busy is ignored.
        run_op(10'h155, 1'b1);

        // Reset while in ROTATE.
        run_op(10'h0F3, 1'b0);
        @(negedge CLK);
        I_NUM   = 10'h18C;
        I_START = 1'b1;
        @(negedge CLK);
        I_START = 1'b0;
        draw(m_lfsr, sh, tries);
        for (int i = 0; i < tries; i++) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("rot_rst_num", 32'(O_NUM), 32'd0);
        check("rot_rst_valid", 32'(O_VALID), 32'd0);
        check("rot_rst_busy", 32'(O_BUSY), 32'd0);
        check("rot_rst_shift", 32'(O_SHIFT), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (O_VALID) pulses++;
        end
        check("rot_rst_no_valid", 32'(pulses), 32'd0);
        run_op(10'h18C, 1'b0);

        // START held high: back-to-back operations, no overlap.
        @(negedge CLK);
        I_NUM   = 10'h2C7;
        I_START = 1'b1;
        pulses  = 0;
        prev_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (prev_valid) check("held_restart", 32'(O_BUSY), 32'd1);
            prev_valid = O_VALID;
            if (O_VALID) begin
                pulses++;
                check("held_busy_low", 32'(O_BUSY), 32'd0);
                check("held_num", 32'(O_NUM), 32'(rotl(perm(10'h2C7), int'(O_SHIFT))));
            end
        end
        I_START = 1'b0;
        check("held_pulses", 32'(pulses > 0), 32'd1);
        n = 0;
        while (n < 40 && (O_BUSY || O_VALID)) begin
            @(negedge CLK);
            n++;
        end
        check("held_drain", 32'(O_BUSY), 32'd0);

        // Random inputs against the model.
        for (int i = 0; i < 200; i++) run_op(10'($urandom), 1'b0);

`ifdef SEED_LOAD_EN
        @(negedge CLK);
        I_SEED_LD = 1'b1;
        I_SEED    = 16'h1234;
        @(negedge CLK);
        I_SEED_LD = 1'b0;
        run_op(10'h001, 1'b0);
        s1 = O_SHIFT;
        @(negedge CLK);
        I_SEED_LD = 1'b1;
        I_SEED    = 16'h1234;
        @(negedge CLK);
        I_SEED_LD = 1'b0;
        run_op(10'h001, 1'b0);
        check("seed_repeat", 32'(O_SHIFT), 32'(s1));
        I_SEED_LD = 1'b1;
        I_SEED    = 16'h0000;
        @(negedge CLK);
        I_SEED_LD = 1'b0;
        check("seed_zero", 32'(dut.lfsr_q), 32'h0001);
`else
        s1 = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
